// File: rtl/branch_predict_2lvl_pkg.sv
// Shared definitions for the two-level branch predictor: counter encodings,
// index modes, decode constants and the init/run state type.
package bp_pkg;
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  localparam int INDEX_LOCAL  = 0;
  localparam int INDEX_GSHARE = 1;

  localparam logic [5:0] OP_REGIMM = 6'b000001;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} bp_state_e;

  function automatic logic [1:0] cnt_update(input logic [1:0] c, input logic taken);
    if (taken) return (c == ST) ? ST : c + 2'd1;
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction
endpackage

// File: rtl/branch_predict_2lvl_if.sv
// Pipeline-facing signals of the predictor: D-stage decode/prediction,
// F-stage fetch PC and M-stage resolution.
interface branch_predict_2lvl_if;
  logic        flushD;
  logic        stallD;
  logic [31:0] instrD;
  logic [31:0] pcF;
  logic [31:0] pcM;
  logic        branchM;
  logic        actual_takeM;
  logic        pred_takeM;
  logic        branchD;
  logic        branchL_D;
  logic        pred_takeD;
  logic        init_busy;

  modport master (
    output flushD, stallD, instrD, pcF, pcM, branchM, actual_takeM, pred_takeM,
    input  branchD, branchL_D, pred_takeD, init_busy
  );

  modport slave (
    input  flushD, stallD, instrD, pcF, pcM, branchM, actual_takeM, pred_takeM,
    output branchD, branchL_D, pred_takeD, init_busy
  );
endinterface

// File: rtl/branch_predict_2lvl_perf.sv
// Saturating event counter; sticks at all-ones, cleared by rst.
module bp_perf_counter #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [PERF_W-1:0] cnt
);
  logic [PERF_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + PERF_W'(1);
    end
  end

  assign cnt = r_cnt;
endmodule

// File: rtl/branch_predict_2lvl.sv
// Two-level branch direction predictor: predicts in F, registers into D and
// trains from resolved M-stage branches, with local or gshare PHT indexing.
module branch_predict_2lvl
  import bp_pkg::*;
#(
  parameter int         BHT_DEPTH  = 10,
  parameter int         PHT_DEPTH  = 6,
  parameter int         INDEX_MODE = INDEX_LOCAL,
  parameter logic [1:0] CNT_INIT   = WT,
  parameter int         PERF_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_predict_2lvl_if.slave bus,
  output logic [PERF_W-1:0]    perf_branch_cnt,
  output logic [PERF_W-1:0]    perf_miss_cnt
);
  localparam int BHT_N = 1 << BHT_DEPTH;
  localparam int PHT_N = 1 << PHT_DEPTH;
  localparam int IDX_W = (BHT_DEPTH > PHT_DEPTH) ? BHT_DEPTH : PHT_DEPTH;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  bp_state_e            r_state;
  bp_state_e            w_state_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [PHT_DEPTH-1:0] r_bht [BHT_N];
  logic [1:0]           r_pht [PHT_N];
  logic [PHT_DEPTH-1:0] r_ghr;
  logic                 r_pred_p1;

  logic [5:0]           w_op;
  logic [2:0]           w_rt;
  logic                 w_run;
  logic [BHT_DEPTH-1:0] w_bht_idx_f;
  logic [BHT_DEPTH-1:0] w_bht_idx_m;
  logic [PHT_DEPTH-1:0] w_h_f;
  logic [PHT_DEPTH-1:0] w_h_m;
  logic                 w_pred_f;
  logic                 w_train;
  logic                 w_miss;
  logic                 w_unused;

  assign w_op = bus.instrD[31:26];
  assign w_rt = bus.instrD[19:17];

  assign bus.branchD   = (w_op == OP_REGIMM && (w_rt == 3'b000 || w_rt == 3'b001))
                       || w_op[5:2] == 4'b0001 || w_op[5:2] == 4'b0101;
  assign bus.branchL_D = (w_op == OP_REGIMM && w_rt == 3'b001) || w_op[5:2] == 4'b0101;

  // F and M compute their PHT index with the same formula
  assign w_bht_idx_f = bus.pcF[BHT_DEPTH+1:2];
  assign w_bht_idx_m = bus.pcM[BHT_DEPTH+1:2];
  assign w_h_f = (INDEX_MODE == INDEX_GSHARE) ? (r_ghr ^ bus.pcF[PHT_DEPTH+1:2])
                                              : r_bht[w_bht_idx_f];
  assign w_h_m = (INDEX_MODE == INDEX_GSHARE) ? (r_ghr ^ bus.pcM[PHT_DEPTH+1:2])
                                              : r_bht[w_bht_idx_m];

  assign w_pred_f = w_run & r_pht[w_h_f][1];
  assign w_train  = w_run & bus.branchM;
  assign w_miss   = w_train & (bus.pred_takeM ^ bus.actual_takeM);
  assign w_unused = ^{bus.pcF, bus.pcM, bus.instrD};

  always_comb begin
    w_state_nxt   = r_state;
    w_run         = (r_state == S_RUN);
    bus.init_busy = (r_state == S_INIT);
    if (r_state == S_INIT && r_idx == IDX_LAST) w_state_nxt = S_RUN;
  end

  // Sweep and training share one writer so tables never see two drivers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) begin
        r_idx <= r_idx + IDX_W'(1);
        r_ghr <= '0;
        if (int'(r_idx) < BHT_N) r_bht[r_idx[BHT_DEPTH-1:0]] <= '0;
        if (int'(r_idx) < PHT_N) r_pht[r_idx[PHT_DEPTH-1:0]] <= CNT_INIT;
      end else if (w_train) begin
        r_pht[w_h_m] <= cnt_update(r_pht[w_h_m], bus.actual_takeM);
        if (INDEX_MODE == INDEX_GSHARE) begin
          r_ghr <= {r_ghr[PHT_DEPTH-2:0], bus.actual_takeM};
        end else begin
          r_bht[w_bht_idx_m] <= {r_bht[w_bht_idx_m][PHT_DEPTH-2:0], bus.actual_takeM};
        end
      end
    end
  end

  // F -> D stage boundary
  always_ff @(posedge clk) begin
    if (rst || bus.flushD) begin
      r_pred_p1 <= 1'b0;
    end else if (!bus.stallD) begin
      r_pred_p1 <= w_pred_f;
    end
  end

  assign bus.pred_takeD = bus.branchD & r_pred_p1;

  bp_perf_counter #(.PERF_W(PERF_W)) u_perf_branch (
    .clk (clk),
    .rst (rst),
    .inc (w_train),
    .cnt (perf_branch_cnt)
  );

  bp_perf_counter #(.PERF_W(PERF_W)) u_perf_miss (
    .clk (clk),
    .rst (rst),
    .inc (w_miss),
    .cnt (perf_miss_cnt)
  );
endmodule
